dm_port_arbiter: RTL

Arbitrates the single external data-memory port (`m_data_*`) between the CPU's M-stage load/store path and a word-burst DMA requester. The CPU has default priority. A starvation counter forces DMA service after a bounded number of lost cycles; while DMA owns the port, the CPU pipeline is stalled. Within a DMA burst the block generates the word addresses itself and returns read data with one-cycle memory latency.

---
 rtl/dm_port_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: CPU M-stage access vs. word-burst DMA, with a
// starvation guard that forces DMA service and stalls the CPU while DMA owns the port.
module dm_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  input  logic        cpu_flush,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_base,
  input  logic [3:0]  dma_len,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic        dma_done,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic        m_data_re,
  input  logic [31:0] m_data_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BURST = 2'd1} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_DMA = 2'd2} owner_t;

  state_t           state, state_n;
  owner_t           rd_owner, rd_owner_n;
  logic [3:0]       beat, beat_n;
  logic [3:0]       len_q, len_n;
  logic [31:0]      base_q, base_n;
  logic             we_q, we_n;
  logic [CNT_W-1:0] starve, starve_n;

  logic        cpu_v;
  logic        grant_cpu;
  logic        grant_dma;
  logic [31:0] cur_addr;
  logic        cur_we;
  logic        at_limit;

  assign cpu_v    = cpu_req & ~cpu_flush;
  assign at_limit = (starve == CNT_W'(STARVE_LIMIT));

  // DMA handshake: dma_req is held until dma_done; each cycle with dma_ack=1
  // is one beat accepted by memory, and dma_done marks the last of them.
  always_comb begin
    state_n   = state;
    beat_n    = beat;
    len_n     = len_q;
    base_n    = base_q;
    we_n      = we_q;
    starve_n  = starve;
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    dma_ack   = 1'b0;
    dma_done  = 1'b0;
    cpu_stall = 1'b0;
    cur_addr  = base_q + {26'd0, beat, 2'b00};
    cur_we    = we_q;
    if (reset) begin
      case (state)
        S_IDLE: begin
          if (!dma_req) begin
            grant_cpu = cpu_v;
            starve_n  = '0;
          end else if (cpu_v && !at_limit) begin
            grant_cpu = 1'b1;
            starve_n  = starve + CNT_W'(1);
          end else begin
            // Beat 0 goes out from the live inputs, so BURST resumes at beat 1.
            grant_dma = 1'b1;
            dma_ack   = 1'b1;
            cur_addr  = dma_base;
            cur_we    = dma_we;
            cpu_stall = cpu_v;
            base_n    = dma_base;
            len_n     = dma_len;
            we_n      = dma_we;
            if (cpu_v) starve_n = '0;
            if (dma_len == 4'd0) begin
              dma_done = 1'b1;
              beat_n   = 4'd0;
            end else begin
              beat_n  = 4'd1;
              state_n = S_BURST;
            end
          end
        end
        S_BURST: begin
          grant_dma = 1'b1;
          dma_ack   = 1'b1;
          cpu_stall = cpu_v;
          beat_n    = beat + 4'd1;
          if (beat == len_q) begin
            dma_done = 1'b1;
            state_n  = S_IDLE;
            starve_n = '0;
            beat_n   = 4'd0;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    m_data_addr   = 32'd0;
    m_data_wdata  = 32'd0;
    m_data_byteen = 4'd0;
    m_data_re     = 1'b0;
    rd_owner_n    = OWN_NONE;
    if (grant_cpu) begin
      m_data_addr   = cpu_addr;
      m_data_wdata  = cpu_wdata;
      m_data_byteen = cpu_we ? cpu_byteen : 4'd0;
      m_data_re     = ~cpu_we;
      if (!cpu_we) rd_owner_n = OWN_CPU;
    end else if (grant_dma) begin
      m_data_addr   = cur_addr;
      m_data_wdata  = dma_wdata;
      m_data_byteen = cur_we ? 4'hF : 4'd0;
      m_data_re     = ~cur_we;
      if (!cur_we) rd_owner_n = OWN_DMA;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      beat     <= 4'd0;
      len_q    <= 4'd0;
      base_q   <= 32'd0;
      we_q     <= 1'b0;
      starve   <= '0;
      rd_owner <= OWN_NONE;
    end else begin
      state    <= state_n;
      beat     <= beat_n;
      len_q    <= len_n;
      base_q   <= base_n;
      we_q     <= we_n;
      starve   <= starve_n;
      rd_owner <= rd_owner_n;
    end
  end

  assign cpu_rdata  = reset ? m_data_rdata : 32'd0;
  assign dma_rdata  = reset ? m_data_rdata : 32'd0;
  assign dma_rvalid = reset && (rd_owner == OWN_DMA);
  assign dbg_state  = state;

endmodule
